// File: rtl/lut_neuron_table_loader.sv
// Runtime-loadable LUT neuron: packed truth-table stream in, one registered lookup per cycle out.
// Optional LUT_LOADER_CHECKSUM_EN adds a mod-2^16 word checksum compared against chk_expected.
module lut_neuron_table_loader #(
  parameter int unsigned IN_BITS  = 8,
  parameter int unsigned OUT_BITS = 2,
  parameter int unsigned WORD_W   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_start,
  input  logic [WORD_W-1:0]   s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic                loaded,
  input  logic [IN_BITS-1:0]  in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [OUT_BITS-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready
`ifdef LUT_LOADER_CHECKSUM_EN
  ,
  input  logic [15:0]         chk_expected,
  output logic                chk_err
`endif
);

  // Entries per word is assumed to be a power of two >= 2, so an address splits into word/entry fields.
  localparam int unsigned EPW    = WORD_W / OUT_BITS;
  localparam int unsigned DEPTH  = 1 << IN_BITS;
  localparam int unsigned NWORDS = DEPTH / EPW;
  localparam int unsigned SEL_W  = $clog2(EPW);
  localparam int unsigned CNT_W  = IN_BITS - SEL_W;

  typedef enum logic [1:0] {EMPTY, LOAD, RUN} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic                wr_en;
  logic                last_word;
  logic                rd_fire;
  logic [WORD_W-1:0]   mem [NWORDS];
  logic [WORD_W-1:0]   rd_word;
  logic [OUT_BITS-1:0] rd_entry;

  assign last_word = (cnt == CNT_W'(NWORDS - 1));

  // Next-state and word-write decode; load_start always wins over a coincident beat.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wr_en     = 1'b0;
    case (state)
      EMPTY: begin
        if (load_start) begin
          state_nxt = LOAD;
          cnt_nxt   = '0;
        end
      end
      LOAD: begin
        if (load_start) begin
          cnt_nxt = '0;
        end else if (s_valid) begin
          wr_en = 1'b1;
          if (last_word) begin
            cnt_nxt   = '0;
            state_nxt = RUN;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      RUN: begin
        if (load_start) begin
          state_nxt = LOAD;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = EMPTY;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= EMPTY;
      cnt     <= '0;
      s_ready <= 1'b0;
      loaded  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      s_ready <= (state_nxt == LOAD);
      loaded  <= (state_nxt == RUN);
    end
  end

  // Table storage, one load word per location; intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[cnt] <= s_data;
    end
  end

  assign rd_word = mem[in_data[IN_BITS-1:SEL_W]];

  always_comb begin
    rd_entry = '0;
    for (int unsigned k = 0; k < EPW; k++) begin
      if (in_data[SEL_W-1:0] == SEL_W'(k)) begin
        rd_entry = rd_word[k*OUT_BITS +: OUT_BITS];
      end
    end
  end

  assign in_ready = (state == RUN) && !load_start && (!out_valid || out_ready);
  assign rd_fire  = in_valid && in_ready;

  // Single-entry output stage; a held result survives a reload until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (rd_fire) begin
      out_valid <= 1'b1;
      out_data  <= rd_entry;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef LUT_LOADER_CHECKSUM_EN
  logic [15:0] chk_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_sum <= '0;
      chk_err <= 1'b0;
    end else if (load_start) begin
      chk_sum <= '0;
      chk_err <= 1'b0;
    end else if (wr_en) begin
      chk_sum <= chk_sum + 16'(s_data);
      if (last_word) begin
        chk_err <= ((chk_sum + 16'(s_data)) != chk_expected);
      end
    end
  end
`endif

endmodule

// File: tb/tb_lut_neuron_table_loader.sv
// Scoreboard bench for lut_neuron_table_loader: random loads/lookups against an array table model.
// Build with LUT_LOADER_CHECKSUM_EN defined to also exercise the checksum ports.
module tb_lut_neuron_table_loader;

  localparam int IN_BITS  = 8;
  localparam int OUT_BITS = 2;
  localparam int WORD_W   = 8;
  localparam int EPW      = WORD_W / OUT_BITS;
  localparam int DEPTH    = 1 << IN_BITS;
  localparam int NWORDS   = DEPTH / EPW;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                load_start;
  logic [WORD_W-1:0]   s_data;
  logic                s_valid;
  logic                s_ready;
  logic                loaded;
  logic [IN_BITS-1:0]  in_data;
  logic                in_valid;
  logic                in_ready;
  logic [OUT_BITS-1:0] out_data;
  logic                out_valid;
  logic                out_ready;
`ifdef LUT_LOADER_CHECKSUM_EN
  logic [15:0]         chk_expected;
  logic                chk_err;
`endif

  always #5 clk = ~clk;

  lut_neuron_table_loader #(
    .IN_BITS (IN_BITS),
    .OUT_BITS(OUT_BITS),
    .WORD_W  (WORD_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_start(load_start),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .loaded    (loaded),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef LUT_LOADER_CHECKSUM_EN
    ,
    .chk_expected(chk_expected),
    .chk_err     (chk_err)
`endif
  );

  int nvec = 0;
  int nerr = 0;

  // Reference model: plain table array, phase (0 empty, 1 loading, 2 serving), words taken so far.
  logic [OUT_BITS-1:0] tbl [DEPTH];
  logic [OUT_BITS-1:0] sbq [$];
  int                  mphase;
  int                  widx;
  logic [15:0]         msum;
  logic                merr;
  logic                lk_fire;

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: any presented result must match the oldest outstanding expectation.
  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      chk("out_valid", int'(out_valid), int'(sbq.size() != 0));
      if (out_valid && sbq.size() != 0) begin
        chk("out_data", int'(out_data), int'(sbq[0]));
        if (out_ready) void'(sbq.pop_front());
      end
    end
  end

  task automatic step(input logic ls, input logic sv, input logic [WORD_W-1:0] sd,
                      input logic iv, input logic [IN_BITS-1:0] id, input logic ordy);
    logic exp_ir;
    logic s_acc;
    @(negedge clk);
    load_start = ls;
    s_valid    = sv;
    s_data     = sd;
    in_valid   = iv;
    in_data    = id;
    out_ready  = ordy;
    #2;
    chk("s_ready", int'(s_ready), int'(mphase == 1));
    chk("loaded", int'(loaded), int'(mphase == 2));
    exp_ir = (mphase == 2) && !ls && (sbq.size() == 0);
    chk("in_ready", int'(in_ready), int'(exp_ir));
`ifdef LUT_LOADER_CHECKSUM_EN
    chk("chk_err", int'(chk_err), int'(merr));
`endif
    lk_fire = iv && exp_ir;
    if (lk_fire) sbq.push_back(tbl[id]);
    s_acc = sv && (mphase == 1) && !ls;
    if (ls) begin
      mphase = 1;
      widx   = 0;
      msum   = '0;
      merr   = 1'b0;
    end else if (s_acc) begin
      for (int k = 0; k < EPW; k++) tbl[widx*EPW + k] = sd[k*OUT_BITS +: OUT_BITS];
      msum = msum + 16'(sd);
      widx++;
      if (widx == NWORDS) begin
        mphase = 2;
        widx   = 0;
`ifdef LUT_LOADER_CHECKSUM_EN
        merr = (msum != chk_expected);
`endif
      end
    end
  endtask

  // mode: 0 all-ones, 1 word i = {4{i[1:0]}}, 2 random, 3 all 8'h01; gap = % of idle beats.
  task automatic load_words(input int n, input int mode, input int gap);
    int got = 0;
    int guard = 0;
    logic [1:0] b;
    logic [WORD_W-1:0] w;
    logic sv;
    while (got < n && guard < 2000) begin
      guard++;
      b = widx[1:0];
      case (mode)
        0:       w = 8'hFF;
        1:       w = {4{b}};
        2:       w = WORD_W'($urandom);
        default: w = 8'h01;
      endcase
      sv = ($urandom_range(99) >= gap);
      step(1'b0, sv, w, 1'($urandom_range(1)), IN_BITS'($urandom), 1'b1);
      if (sv) got++;
    end
    if (got < n) chk("load_timeout", got, n);
  endtask

  task automatic look(input logic [IN_BITS-1:0] a);
    int g = 0;
    do begin
      step(1'b0, 1'b0, '0, 1'b1, a, 1'b1);
      g++;
    end while (!lk_fire && g < 50);
    if (!lk_fire) chk("lookup_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    int fires;
    rst_n      = 1'b0;
    load_start = 1'b0;
    s_valid    = 1'b0;
    s_data     = '0;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b0;
`ifdef LUT_LOADER_CHECKSUM_EN
    chk_expected = '0;
`endif
    mphase = 0;
    widx   = 0;
    msum   = '0;
    merr   = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_s_ready", int'(s_ready), 0);
    chk("rst_loaded", int'(loaded), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    @(negedge clk) rst_n = 1'b1;

    // All-ones table with s_valid held for 64 beats.
    idle(2);
    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
    load_words(NWORDS, 0, 0);
    look(8'h00);
    look(8'hA5);
    idle(3);

    // Patterned table, directed addresses, then back-to-back lookups.
    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
    load_words(NWORDS, 1, 25);
    look(8'h0C);
    look(8'h13);
    fires = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b0, '0, 1'b1, IN_BITS'($urandom), 1'b1);
      if (lk_fire) fires++;
    end
    chk("throughput", fires, 40);
    idle(2);

    // Output backpressure: held result then release issues the queued request.
    step(1'b0, 1'b0, '0, 1'b1, 8'h0C, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b1, 8'h13, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 8'h13, 1'b1);
    for (int i = 0; i < 200; i++)
      step(1'b0, 1'b0, '0, 1'($urandom_range(1)), IN_BITS'($urandom), 1'($urandom_range(1)));
    idle(2);

    // Reload with a pending result, abort after 30 words, then a fresh full table.
    step(1'b0, 1'b0, '0, 1'b1, IN_BITS'($urandom), 1'b0);
    step(1'b1, 1'b0, '0, 1'b1, IN_BITS'($urandom), 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    load_words(30, 2, 20);
    step(1'b1, 1'b1, WORD_W'($urandom), 1'b0, '0, 1'b1);
    load_words(NWORDS, 2, 30);
    fires = 0;
    for (int a = 0; a < DEPTH; a++) begin
      step(1'b0, 1'b0, '0, 1'b1, IN_BITS'(a), 1'b1);
      if (lk_fire) fires++;
    end
    chk("full_sweep", fires, DEPTH);
    idle(2);

    // Reset at word 40 of a reload, with a lookup outstanding.
    step(1'b0, 1'b0, '0, 1'b1, IN_BITS'($urandom), 1'b0);
    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    load_words(40, 2, 0);
    step(1'b0, 1'b1, WORD_W'($urandom), 1'b0, '0, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_s_ready", int'(s_ready), 0);
    chk("mid_rst_loaded", int'(loaded), 0);
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_out_data", int'(out_data), 0);
    load_start = 1'b0;
    s_valid    = 1'b0;
    in_valid   = 1'b0;
    sbq.delete();
    mphase = 0;
    widx   = 0;
    msum   = '0;
    merr   = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h5A, 1'b1, IN_BITS'($urandom), 1'b1);
    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
    load_words(NWORDS, 2, 20);
    for (int i = 0; i < 50; i++)
      step(1'b0, 1'b0, '0, 1'($urandom_range(1)), IN_BITS'($urandom), 1'($urandom_range(1)));
    idle(2);

`ifdef LUT_LOADER_CHECKSUM_EN
    chk_expected = 16'h0040;
    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
    load_words(NWORDS, 3, 0);
    idle(1);
    chk("chk_match", int'(chk_err), 0);
    chk_expected = 16'h0041;
    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
    load_words(NWORDS, 3, 10);
    idle(1);
    chk("chk_mismatch", int'(chk_err), 1);
    look(8'h00);
    idle(2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
